// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Fetch buffer entries pair an instruction word with the PC it was fetched from.
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam int          ILEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with push/pop/flush and an occupancy count.
// Used as the request-tag queue and as the fetch buffer.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0],
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output T              pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the pc register, issues in-order imem requests,
// buffers returned words with their PCs and absorbs redirects with a flush.
//   state | meaning
//   BOOT  | first cycle after reset; next_pc forced to RESET_PC, no requests
//   RUN   | normal fetch; pc_value is trusted
module if_fetch_stage #(
    parameter int              XLEN       = rv_pkg::XLEN,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_value,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
);

    import rv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   tag_count;
    logic            tag_full;
    logic            tag_empty;
    logic            buf_full;
    logic            buf_empty;
    logic            credit_ok;
    logic            fire;
    logic            rsp_drop;
    logic            buf_push;
    logic            buf_pop;
    logic [XLEN-1:0] tag_pc;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;
    logic            unused_ok;

    // Credits cover both outstanding requests and buffered words, so a response always has room.
    assign credit_ok      = ({1'b0, inflight} + {1'b0, buf_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_valid = (state == RUN) & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc_value;
    assign fire           = imem_req_valid & imem_req_ready;

    assign rsp_drop = redirect_valid | (drop_cnt != '0);
    assign buf_push = imem_rsp_valid & ~rsp_drop;
    assign buf_in   = '{pc: tag_pc, instr: imem_rsp_data};

    assign id_valid = ~buf_empty & ~redirect_valid;
    assign buf_pop  = id_valid & id_ready;
    assign id_pc    = buf_head.pc;
    assign id_instr = id_valid ? buf_head.instr : INSTR_NOP;

    assign unused_ok = &{1'b0, tag_count, tag_full, tag_empty, buf_full};

    always_comb begin
        if (state == BOOT)       next_pc = RESET_PC;
        else if (redirect_valid) next_pc = {redirect_pc[XLEN-1:2], 2'b00};
        else if (fire)           next_pc = pc_value + XLEN'(4);
        else                     next_pc = pc_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                default: state <= RUN;
            endcase
            inflight <= inflight + CW'(fire) - CW'(imem_rsp_valid);
            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid)
                drop_cnt <= inflight - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data (pc_value),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .pop_data  (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule
